// File: rtl/dcache_pkg.sv
// Shared types and sizing helpers for the direct-mapped write-through data cache.
package dcache_pkg;

    localparam int WORD_W = 32;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        RD_MISS = 2'd1,
        WR_THRU = 2'd2
    } dcache_state_t;

    // Tag is what remains of the byte address after the word offset and the index.
    function automatic int tag_width(input int addr_w, input int index_bits);
        return addr_w - index_bits - 2;
    endfunction

endpackage

// File: rtl/dcache_array.sv
// Valid/tag/data storage: one asynchronous read port, one synchronous write port.
module dcache_array
    import dcache_pkg::*;
#(
    parameter int INDEX_BITS = 3,
    parameter int TAG_W      = 27
) (
    input  logic                  clk,
    input  logic                  rst_b,
    input  logic [INDEX_BITS-1:0] rd_idx,
    output logic                  rd_valid,
    output logic [TAG_W-1:0]      rd_tag,
    output logic [WORD_W-1:0]     rd_data,
    input  logic                  wr_en,
    input  logic [INDEX_BITS-1:0] wr_idx,
    input  logic [TAG_W-1:0]      wr_tag,
    input  logic [WORD_W-1:0]     wr_data
);

    localparam int LINES = 1 << INDEX_BITS;

    logic [LINES-1:0]  valid;
    logic [TAG_W-1:0]  tag_mem  [LINES];
    logic [WORD_W-1:0] data_mem [LINES];

    always_ff @(posedge clk or negedge rst_b) begin
        if (!rst_b) begin
            valid <= '0;
        end else if (wr_en) begin
            valid[wr_idx] <= 1'b1;
        end
    end

    // NOTE: tag/data arrays carry no reset; cleared valid bits make their contents irrelevant and keep them plain RAM.
    always_ff @(posedge clk) begin
        if (wr_en) begin
            tag_mem[wr_idx]  <= wr_tag;
            data_mem[wr_idx] <= wr_data;
        end
    end

    assign rd_valid = valid[rd_idx];
    assign rd_tag   = tag_mem[rd_idx];
    assign rd_data  = data_mem[rd_idx];

endmodule

// File: rtl/dcache.sv
// Direct-mapped, write-through, no-write-allocate data cache with req/ack backing memory
// and saturating read hit/miss counters.
module dcache
    import dcache_pkg::*;
#(
    parameter int INDEX_BITS = 3,
    parameter int ADDR_W     = 32
) (
    input  logic              clk,
    input  logic              rst_b,
    input  logic [ADDR_W-1:0] cpu_addr,
    input  logic              cpu_rd_en,
    input  logic              cpu_wr_en,
    input  logic [31:0]       cpu_wdata,
    output logic [31:0]       cpu_rdata,
    output logic              cpu_stall,
    output logic              mem_req,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [31:0]       mem_wdata,
    input  logic [31:0]       mem_rdata,
    input  logic              mem_ack,
    output logic [31:0]       hit_count,
    output logic [31:0]       miss_count
);

    localparam int TAG_W = tag_width(ADDR_W, INDEX_BITS);

    localparam logic [1:0] ST_IDLE    = 2'(IDLE);
    localparam logic [1:0] ST_RD_MISS = 2'(RD_MISS);
    localparam logic [1:0] ST_WR_THRU = 2'(WR_THRU);

    logic [1:0]            state, state_nxt;
    logic                  ack_done;
    logic [INDEX_BITS-1:0] idx;
    logic [TAG_W-1:0]      tag;
    logic                  line_valid;
    logic [TAG_W-1:0]      line_tag;
    logic [WORD_W-1:0]     line_data;
    logic                  hit;
    logic                  arr_we;
    logic                  stall_c;
    logic                  cnt_hit, cnt_miss;
    logic                  unused_addr_bits;

    assign idx              = cpu_addr[INDEX_BITS+1:2];
    assign tag              = cpu_addr[ADDR_W-1:INDEX_BITS+2];
    assign hit              = line_valid && (line_tag == tag);
    assign mem_addr         = {cpu_addr[ADDR_W-1:2], 2'b00};
    assign mem_wdata        = cpu_wdata;
    assign unused_addr_bits = ^cpu_addr[1:0];

    dcache_array #(
        .INDEX_BITS(INDEX_BITS),
        .TAG_W     (TAG_W)
    ) u_array (
        .clk     (clk),
        .rst_b   (rst_b),
        .rd_idx  (idx),
        .rd_valid(line_valid),
        .rd_tag  (line_tag),
        .rd_data (line_data),
        .wr_en   (arr_we),
        .wr_idx  (idx),
        .wr_tag  (tag),
        .wr_data ((state == ST_WR_THRU) ? cpu_wdata : mem_rdata)
    );

    // ack_done marks the replay cycle after an ack: the held request completes
    // without stalling, re-issuing, or being counted again.
    // NOTE: every output of this block gets a default first so no path infers a latch.
    always_comb begin
        state_nxt = state;
        stall_c   = 1'b0;
        cpu_rdata = '0;
        arr_we    = 1'b0;
        cnt_hit   = 1'b0;
        cnt_miss  = 1'b0;
        case (state)
            ST_IDLE: begin
                if (cpu_rd_en && hit && (ack_done || !cpu_wr_en)) begin
                    cpu_rdata = line_data;
                end
                if (!ack_done) begin
                    if (cpu_wr_en) begin
                        stall_c   = 1'b1;
                        state_nxt = ST_WR_THRU;
                    end else if (cpu_rd_en) begin
                        if (hit) begin
                            cnt_hit = 1'b1;
                        end else begin
                            stall_c   = 1'b1;
                            cnt_miss  = 1'b1;
                            state_nxt = ST_RD_MISS;
                        end
                    end
                end
            end
            ST_RD_MISS: begin
                stall_c = 1'b1;
                if (mem_ack) begin
                    arr_we    = 1'b1;
                    state_nxt = ST_IDLE;
                end
            end
            ST_WR_THRU: begin
                stall_c = 1'b1;
                if (mem_ack) begin
                    arr_we    = hit;
                    state_nxt = ST_IDLE;
                end
            end
            default: state_nxt = ST_IDLE;
        endcase
    end

    // Stall is forced low while reset is held, whatever the request inputs do.
    assign cpu_stall = stall_c & rst_b;

    // NOTE: state is sequential, so it is updated with non-blocking assignments only.
    always_ff @(posedge clk or negedge rst_b) begin
        if (!rst_b) begin
            state      <= ST_IDLE;
            ack_done   <= 1'b0;
            mem_req    <= 1'b0;
            mem_we     <= 1'b0;
            hit_count  <= '0;
            miss_count <= '0;
        end else begin
            state    <= state_nxt;
            ack_done <= (state != ST_IDLE) && mem_ack;
            mem_req  <= (state_nxt != ST_IDLE);
            mem_we   <= (state_nxt == ST_WR_THRU);
            if (cnt_hit && (hit_count != 32'hFFFF_FFFF)) begin
                hit_count <= hit_count + 32'd1;
            end
            if (cnt_miss && (miss_count != 32'hFFFF_FFFF)) begin
                miss_count <= miss_count + 32'd1;
            end
        end
    end

endmodule
